// File: rtl/top_for_debug_pkg.sv
// Shared definitions for the debug loader/stepper: one-hot states, command
// bytes, HALT opcode and instruction-memory geometry.
package top_for_debug_pkg;

   typedef enum logic [9:0] {
      S_IDLE      = 10'b00_0000_0001,
      S_LOAD      = 10'b00_0000_0010,
      S_RUN       = 10'b00_0000_0100,
      S_STEP_IDLE = 10'b00_0000_1000,
      S_STEP_EXEC = 10'b00_0001_0000,
      S_TX_LOAD   = 10'b00_0010_0000,
      S_TX_WAIT   = 10'b00_0100_0000,
      S_TX_NEXT   = 10'b00_1000_0000,
      S_DONE      = 10'b01_0000_0000,
      S_CLEAR     = 10'b10_0000_0000
   } state_e;

   // Where CLEAR hands control once the counters are zeroed.
   typedef enum logic [1:0] {
      CN_IDLE,
      CN_RUN,
      CN_STEP
   } clr_next_e;

   localparam logic [7:0] CMD_LOAD      = 8'd1;
   localparam logic [7:0] CMD_RUN       = 8'd2;
   localparam logic [7:0] CMD_STEP      = 8'd3;
   localparam logic [7:0] CMD_STEP_GO   = 8'd4;
   localparam logic [7:0] CMD_STEP_QUIT = 8'd5;

   localparam logic [5:0] HALT_OP = 6'b111111;

   localparam int IM_BYTES   = 256;
   localparam int IM_WORDS   = IM_BYTES / 4;
   localparam int REPORT_LEN = 8;
   localparam int PC_W       = $clog2(IM_WORDS);
   localparam int IDX_W      = $clog2(IM_BYTES);

   // The program stops on an explicit HALT or when it reaches the last word.
   function automatic logic is_halt(input logic [5:0] opcode, input logic [PC_W-1:0] pc);
      return (opcode == HALT_OP) || (pc == PC_W'(IM_WORDS - 1));
   endfunction

endpackage

// File: rtl/top_for_debug_instr_mem.sv
// Instruction memory: byte-wide write port for UART loading, combinational
// big-endian word read port for fetch. Contents survive reset.
module debug_instr_mem
   import top_for_debug_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_waddr,
   input  logic [7:0]       i_wdata,
   input  logic [PC_W-1:0]  i_raddr,
   output logic [31:0]      o_rdata
);

   logic [7:0] mem_q [IM_BYTES];

   always_ff @(posedge i_clock) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = {mem_q[{i_raddr, 2'd0}], mem_q[{i_raddr, 2'd1}],
                     mem_q[{i_raddr, 2'd2}], mem_q[{i_raddr, 2'd3}]};

endmodule

// File: rtl/top_for_debug.sv
// Debug controller: loads a program over UART, runs or single-steps it, and
// reports PC and cycle count back as eight bytes, LSB first.
module top_for_debug
   import top_for_debug_pkg::*;
#(
   parameter int BYTE    = 8,
   parameter int DWORD   = 32,
   parameter int ADDR    = 5,
   parameter int RB_ADDR = 5
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_clock_reset,
   input  logic            i_rx_done,
   input  logic [BYTE-1:0] i_rx_data,
   input  logic            i_tx_done,
   output logic [BYTE-1:0] o_tx_data,
   output logic            o_tx_start,
   output logic            o_halt,
   output logic [9:0]      o_state
);

   localparam int unused_reserved_w = ADDR + RB_ADDR;

   logic             rst;
   state_e           state_q, state_d;
   clr_next_e        clr_next_q, clr_next_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [DWORD-1:0] cyc_q, cyc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       tx_cnt_q, tx_cnt_d;
   logic             halt_q, halt_d;
   logic             mem_we;
   logic             halt_now;
   logic [DWORD-1:0] fetch_w;
   logic [2*DWORD-1:0] report_w;
   logic             unused_fetch_bits;

   assign rst = i_reset | i_clock_reset;

   debug_instr_mem u_mem (
      .i_clock (i_clock),
      .i_we    (mem_we),
      .i_waddr (idx_q),
      .i_wdata (i_rx_data),
      .i_raddr (pc_q),
      .o_rdata (fetch_w)
   );

   assign halt_now          = is_halt(fetch_w[DWORD-1 -: 6], pc_q);
   assign unused_fetch_bits = ^fetch_w[DWORD-7:0];
   assign report_w          = {cyc_q, {(DWORD-PC_W){1'b0}}, pc_q};

   always_ff @(posedge i_clock or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         clr_next_q <= CN_IDLE;
         pc_q       <= '0;
         cyc_q      <= '0;
         idx_q      <= '0;
         tx_cnt_q   <= '0;
         halt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_next_q <= clr_next_d;
         pc_q       <= pc_d;
         cyc_q      <= cyc_d;
         idx_q      <= idx_d;
         tx_cnt_q   <= tx_cnt_d;
         halt_q     <= halt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_next_d = clr_next_q;
      pc_d       = pc_q;
      cyc_d      = cyc_q;
      idx_d      = idx_q;
      tx_cnt_d   = tx_cnt_q;
      halt_d     = halt_q;
      mem_we     = 1'b0;
      o_tx_start = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (i_rx_done) begin
               if (i_rx_data == CMD_LOAD) begin
                  state_d = S_LOAD;
               end else if (i_rx_data == CMD_RUN) begin
                  state_d    = S_CLEAR;
                  clr_next_d = CN_RUN;
               end else if (i_rx_data == CMD_STEP) begin
                  state_d    = S_CLEAR;
                  clr_next_d = CN_STEP;
               end
            end
         end
         S_LOAD: begin
            if (i_rx_done) begin
               mem_we = 1'b1;
               idx_d  = idx_q + 1'b1;
               if (idx_q == IDX_W'(IM_BYTES - 1)) begin
                  state_d    = S_CLEAR;
                  clr_next_d = CN_IDLE;
               end
            end
         end
         S_CLEAR: begin
            pc_d     = '0;
            cyc_d    = '0;
            idx_d    = '0;
            tx_cnt_d = '0;
            halt_d   = 1'b0;
            unique case (clr_next_q)
               CN_RUN:  state_d = S_RUN;
               CN_STEP: state_d = S_STEP_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
         S_RUN, S_STEP_EXEC: begin
            // One fetch per cycle; a halting fetch still counts as a cycle.
            cyc_d    = cyc_q + 1'b1;
            tx_cnt_d = '0;
            if (halt_now) halt_d = 1'b1;
            else          pc_d   = pc_q + 1'b1;
            if (halt_now || state_q == S_STEP_EXEC) state_d = S_TX_LOAD;
         end
         S_STEP_IDLE: begin
            if (i_rx_done) begin
               if (i_rx_data == CMD_STEP_GO)        state_d = S_STEP_EXEC;
               else if (i_rx_data == CMD_STEP_QUIT) state_d = S_IDLE;
            end
         end
         S_TX_LOAD: begin
            o_tx_start = 1'b1;
            state_d    = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (i_tx_done) state_d = S_TX_NEXT;
         end
         S_TX_NEXT: begin
            if (tx_cnt_q == 3'(REPORT_LEN - 1)) begin
               state_d = halt_q ? S_DONE : S_STEP_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
               state_d  = S_TX_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The byte counter only moves in TX_NEXT, so the data is stable through TX_WAIT.
   always_comb begin
      o_tx_data = '0;
      if (state_q == S_TX_LOAD || state_q == S_TX_WAIT || state_q == S_TX_NEXT)
         o_tx_data = report_w[int'(tx_cnt_q)*BYTE +: BYTE];
   end

   assign o_halt  = halt_q;
   assign o_state = state_q;

endmodule

// File: tb/tb_top_for_debug.sv
// Bench for top_for_debug: command tables, fixed programs and random programs
// checked against a word-level model of fetch/halt behaviour.
module tb_top_for_debug;

   logic       clk = 1'b0;
   logic       i_reset, i_clock_reset;
   logic       i_rx_done, i_tx_done;
   logic [7:0] i_rx_data;
   logic [7:0] o_tx_data;
   logic       o_tx_start, o_halt;
   logic [9:0] o_state;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [7:0] cmd;
      logic [9:0] exp_state;
   } vec_t;

   vec_t idle_vecs[6];
   vec_t step_vecs[6];

   logic [7:0] model_mem [256];
   int m_pc, m_cyc;
   bit m_halt;

   top_for_debug dut (
      .i_clock       (clk),
      .i_reset       (i_reset),
      .i_clock_reset (i_clock_reset),
      .i_rx_done     (i_rx_done),
      .i_rx_data     (i_rx_data),
      .i_tx_done     (i_tx_done),
      .o_tx_data     (o_tx_data),
      .o_tx_start    (o_tx_start),
      .o_halt        (o_halt),
      .o_state       (o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   // Model: the program's word-level behaviour, from PC 0.
   function automatic void model_clear();
      m_pc = 0; m_cyc = 0; m_halt = 1'b0;
   endfunction

   function automatic void model_fetch();
      logic [31:0] w;
      w = {model_mem[4*m_pc], model_mem[4*m_pc+1], model_mem[4*m_pc+2], model_mem[4*m_pc+3]};
      m_cyc++;
      if (w[31:26] == 6'h3f || m_pc == 63) m_halt = 1'b1;
      else m_pc++;
   endfunction

   function automatic logic [63:0] model_report();
      return {32'(m_cyc), 32'(m_pc)};
   endfunction

   task automatic reset_dut(input bit use_clock_reset);
      if (use_clock_reset) i_clock_reset = 1'b1;
      else                 i_reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_reset = 1'b0;
      i_clock_reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge clk);
      i_rx_done = 1'b0;
      i_rx_data = 8'($urandom);
   endtask

   task automatic load_program();
      send_byte(8'd1);
      for (int i = 0; i < 256; i++) begin
         send_byte(model_mem[i]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      check("load_done_state", o_state, 10'h001);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (o_tx_start) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic collect_report(input int hold, output logic [63:0] rep);
      bit ok;
      logic [7:0] d;
      int bad;
      rep = '0;
      for (int b = 0; b < 8; b++) begin
         wait_start(ok);
         if (!ok) begin
            fail_now("tx_start_timeout");
            return;
         end
         d = o_tx_data;
         rep[8*b +: 8] = d;
         @(negedge clk);
         if (hold > 0 && b == 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
               i_rx_done = 1'b1;
               i_rx_data = 8'd2;
               if (o_state != 10'h040 || o_tx_data != d || o_tx_start) bad++;
               @(negedge clk);
            end
            i_rx_done = 1'b0;
            check("tx_hold_violations", bad, 0);
         end
         i_tx_done = 1'b1;
         @(negedge clk);
         i_tx_done = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_run(input int hold, input logic [63:0] exp_rep);
      logic [63:0] got;
      int n;
      exp_q.push_back(exp_rep);
      send_byte(8'd2);
      check("run_clear_state", o_state, 10'h200);
      @(negedge clk);
      n = 0;
      while (o_state == 10'h004 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("run_cycles", n, {32'd0, exp_rep[63:32]});
      check("run_halt_set", o_halt, 1'b1);
      collect_report(hold, got);
      check("run_report", got, exp_q.pop_front());
      check("run_final_state", o_state, 10'h100);
      check("run_halt_held", o_halt, 1'b1);
   endtask

   task automatic enter_step();
      send_byte(8'd3);
      check("step_clear_state", o_state, 10'h200);
      @(negedge clk);
      check("step_idle_state", o_state, 10'h008);
      check("step_halt_cleared", o_halt, 1'b0);
   endtask

   task automatic do_step(input logic [63:0] exp_rep, input bit exp_halt);
      logic [63:0] got;
      exp_q.push_back(exp_rep);
      send_byte(8'd4);
      check("step_exec_state", o_state, 10'h010);
      collect_report(0, got);
      check("step_report", got, exp_q.pop_front());
      check("step_halt", o_halt, exp_halt);
      check("step_state", o_state, exp_halt ? 10'h100 : 10'h008);
   endtask

   initial begin
      i_reset = 1'b0; i_clock_reset = 1'b0;
      i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = 8'd0;
      idle_vecs[0] = '{8'd7,   10'h001};
      idle_vecs[1] = '{8'd0,   10'h001};
      idle_vecs[2] = '{8'd4,   10'h001};
      idle_vecs[3] = '{8'd5,   10'h001};
      idle_vecs[4] = '{8'hff,  10'h001};
      idle_vecs[5] = '{8'd129, 10'h001};
      step_vecs[0] = '{8'd1,   10'h008};
      step_vecs[1] = '{8'd2,   10'h008};
      step_vecs[2] = '{8'd3,   10'h008};
      step_vecs[3] = '{8'd0,   10'h008};
      step_vecs[4] = '{8'hff,  10'h008};
      step_vecs[5] = '{8'd5,   10'h001};

      @(negedge clk);
      reset_dut(1'b0);
      check("reset_state", o_state, 10'h001);
      check("reset_halt", o_halt, 1'b0);
      check("reset_tx_start", o_tx_start, 1'b0);
      check("reset_tx_data", o_tx_data, 8'h00);

      for (int i = 0; i < 6; i++) begin
         send_byte(idle_vecs[i].cmd);
         check("idle_cmd_ignored", o_state, idle_vecs[i].exp_state);
      end

      // HALT at word 3
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      model_mem[12] = 8'hfc;
      load_program();
      do_run(50, {32'd4, 32'd3});

      // Restart from DONE without reloading, two single steps
      enter_step();
      do_step({32'd1, 32'd1}, 1'b0);
      do_step({32'd2, 32'd2}, 1'b0);
      for (int i = 0; i < 6; i++) begin
         send_byte(step_vecs[i].cmd);
         check("step_idle_cmd", o_state, step_vecs[i].exp_state);
      end

      // Abort a load after 100 bytes; memory keeps the earlier program
      send_byte(8'd1);
      for (int i = 0; i < 100; i++) send_byte(model_mem[i]);
      check("partial_load_state", o_state, 10'h002);
      reset_dut(1'b1);
      check("abort_state", o_state, 10'h001);
      check("abort_tx_data", o_tx_data, 8'h00);
      enter_step();
      for (int k = 1; k < 5; k++) begin
         if (k < 4) do_step({32'(k), 32'(k)}, 1'b0);
         else       do_step({32'd4, 32'd3}, 1'b1);
      end

      // Random programs with a planted HALT, then stepping from DONE
      for (int it = 0; it < 3; it++) begin
         int p, nsteps;
         for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom_range(0, 255));
         p = $urandom_range(0, 62);
         model_mem[4*p] = 8'hfc | 8'($urandom_range(0, 3));
         load_program();
         model_clear();
         while (!m_halt) model_fetch();
         do_run(0, model_report());
         enter_step();
         model_clear();
         nsteps = $urandom_range(1, 3);
         for (int s = 0; s < nsteps && !m_halt; s++) begin
            model_fetch();
            do_step(model_report(), m_halt);
         end
         if (!m_halt) begin
            send_byte(8'd5);
            check("step_quit_state", o_state, 10'h001);
         end
      end

      // No HALT anywhere: stops at the last word
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      load_program();
      do_run(0, {32'd64, 32'd63});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/top_for_debug.md
TOP_FOR_DEBUG -- requirements
Module: top_for_debug

Interface
REQ-001 Param BYTE, 8, UART byte width.
REQ-002 Param DWORD, 32, instruction/counter word width.
REQ-003 Param ADDR, 5, reserved data-memory address width; carried, unused in this block.
REQ-004 Param RB_ADDR, 5, reserved register-bank address width; carried, unused in this block.
REQ-005 i_clock  in  1  single system clock; all logic on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_clock_reset  in  1  clock-generator reset, asynchronous, active-high; ORed with i_reset internally.
REQ-008 i_rx_done  in  1  one-cycle pulse: i_rx_data holds a valid received byte.
REQ-009 i_rx_data  in  BYTE  received byte.
REQ-010 i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
REQ-011 o_tx_data  out  BYTE  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-012 o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-013 o_halt  out  1  program has halted.
REQ-014 o_state  out  10  one-hot debug FSM state.

Function
REQ-015 Instruction memory SHALL be 256 bytes = 64 words; word k = {byte 4k, 4k+1, 4k+2, 4k+3} (big-endian).
REQ-016 o_state bits SHALL be: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP_IDLE, 4 STEP_EXEC, 5 TX_LOAD, 6 TX_WAIT, 7 TX_NEXT, 8 DONE, 9 CLEAR.
REQ-017 Bytes SHALL be sampled only on cycles with i_rx_done=1; in IDLE/DONE: 8'd1 -> LOAD, 8'd2 -> CLEAR then RUN, 8'd3 -> CLEAR then STEP_IDLE; other values ignored.
REQ-018 LOAD SHALL store each sampled byte at byte index 0..255 in order; after byte 255 -> CLEAR -> IDLE.
REQ-019 CLEAR (one cycle) SHALL zero PC, cycle counter, byte index and o_halt.
REQ-020 Fetch: each RUN or STEP_EXEC cycle reads word IM[PC] and increments the 32-bit cycle counter.
REQ-021 If fetched opcode [31:26] == 6'b111111 (HALT), or PC == 63, o_halt SHALL be set and PC held; otherwise PC increments.
REQ-022 RUN SHALL continue until halt, then enter TX_LOAD; STEP_EXEC SHALL execute exactly one fetch, then enter TX_LOAD.
REQ-023 STEP_IDLE: 8'd4 -> STEP_EXEC; 8'd5 -> IDLE; others ignored.
REQ-024 Report SHALL be 8 bytes: PC (zero-extended to 32 bits, LSB first), then cycle counter (LSB first).
REQ-025 TX_LOAD drives o_tx_data and pulses o_tx_start one cycle -> TX_WAIT; TX_WAIT holds until i_tx_done -> TX_NEXT; TX_NEXT -> TX_LOAD while bytes remain.
REQ-026 After 8th byte: -> DONE if o_halt=1, else -> STEP_IDLE.
REQ-027 o_halt SHALL remain 1 until CLEAR or reset.
REQ-028 i_rx_done SHALL be ignored in RUN, STEP_EXEC and TX states; i_tx_done ignored outside TX_WAIT.
REQ-029 Command 2/3 from DONE SHALL restart from PC 0 without reloading memory.

Reset
REQ-030 Reset SHALL force IDLE (o_state=10'b0000000001), o_tx_start=0, o_tx_data=0, o_halt=0, PC, counter and index zero.
REQ-031 Reset mid-LOAD or mid-TX SHALL abort immediately; memory contents SHALL NOT be reset.

Structure
REQ-032 Shared package: state one-hot constants, command codes 1-5, HALT opcode, IM depth 256, report length 8.
REQ-033 One sub-module: debug_instr_mem (byte write port, word read port).

Verification
REQ-034 Reset release -> o_state=0x001, o_halt=0, o_tx_start=0.
REQ-035 Cmd 1 + 256 bytes, HALT at word 3 (bytes 12..15 = FC 00 00 00), cmd 2 -> o_halt=1 after 4 RUN cycles; TX 03 00 00 00 04 00 00 00; final o_state=0x100.
REQ-036 Cmd 3, then 8'd4 twice (word 0 non-HALT) -> reports 01 00 00 00 01 00 00 00 then 02 00 00 00 02 00 00 00; o_halt=0; state STEP_IDLE.
REQ-037 i_tx_done withheld 50 cycles -> o_state stays 0x040, o_tx_data stable, no extra o_tx_start.
REQ-038 Cmd byte 8'd7 in IDLE -> state unchanged; reset after 100 LOAD bytes -> IDLE, next byte treated as command.
REQ-039 Memory without HALT, cmd 2 -> halt at PC=63, cycle count 64.
